// File: rtl/i2c_reg_target_if.sv
// I2C register-target bus bundle.
// Carries the I2C pin levels (scl_in, sda_in), the open-drain SDA pull
// (sda_oe) and the register-file side (reg_addr, reg_wdata, reg_we,
// reg_rdata, reg_re) plus the busy flag.
//   slave  : view used by i2c_reg_target (pins/rdata in, everything else out)
//   master : view of the environment that drives pins and serves reg_rdata
interface i2c_reg_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic [7:0] reg_rdata;
   logic       reg_re;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, reg_rdata,
      output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
   );

   modport master (
      output scl_in, sda_in, reg_rdata,
      input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
   );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target with an 8-bit register pointer.
// Serves START/addr+W/ptr/data.../STOP register writes and pointer-then-read
// via repeated START. Open-drain SDA only, SCL is never driven.
// Ports:
//   clk    system clock, at least 16x the SCL rate
//   reset  synchronous, active-high
//   bus    i2c_reg_target_if.slave:
//            scl_in/sda_in  asynchronous pin levels
//            sda_oe         1 = pull SDA low
//            reg_addr       register pointer
//            reg_wdata      write byte, valid with reg_we
//            reg_we         1-clk write strobe
//            reg_rdata      register contents at reg_addr
//            reg_re         1-clk strobe marking a transmit byte load
//            busy           matched transfer in progress
module i2c_reg_target #(
   parameter logic [6:0] DEV_ADDR = 7'h76
) (
   input  logic            clk,
   input  logic            reset,
   i2c_reg_target_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
      RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t     state;
   logic       scl_s1, scl_s2, scl_h;
   logic       sda_s1, sda_s2, sda_h;
   logic [7:0] shift;
   logic [7:0] ptr;
   logic [7:0] wdata;
   logic [3:0] bitcnt;
   logic       rw;
   logic       oe_q, we_q, re_q, busy_q;
   logic       scl_rise, scl_fall, start_c, stop_c;

   // Synchronisers reset to the idle-bus level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_h  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_h  <= 1'b1;
      end else begin
         scl_s1 <= bus.scl_in;
         scl_s2 <= scl_s1;
         scl_h  <= scl_s2;
         sda_s1 <= bus.sda_in;
         sda_s2 <= sda_s1;
         sda_h  <= sda_s2;
      end
   end

   assign scl_rise = scl_s2 & ~scl_h;
   assign scl_fall = ~scl_s2 & scl_h;
   // SCL must be high on both samples so an SCL edge is never read as START/STOP.
   assign start_c  = scl_s2 & scl_h & sda_h & ~sda_s2;
   assign stop_c   = scl_s2 & scl_h & ~sda_h & sda_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         shift  <= '0;
         ptr    <= '0;
         wdata  <= '0;
         bitcnt <= '0;
         rw     <= 1'b0;
         oe_q   <= 1'b0;
         we_q   <= 1'b0;
         re_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         we_q <= 1'b0;
         re_q <= 1'b0;
         // Post-increment after a write, so reg_addr holds the target during reg_we.
         if (we_q) ptr <= ptr + 8'd1;

         if (start_c) begin
            state  <= ADDR;
            bitcnt <= '0;
            oe_q   <= 1'b0;
         end else if (stop_c) begin
            state  <= IDLE;
            bitcnt <= '0;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (bitcnt != 4'd8) begin
                     shift  <= {shift[6:0], sda_s2};
                     bitcnt <= bitcnt + 4'd1;
                  end
               end
               RDATA_ACK: begin
                  // Master NACK ends the read.
                  if (sda_s2) begin
                     state  <= IGNORE;
                     busy_q <= 1'b0;
                     oe_q   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR: begin
                  if (bitcnt == 4'd8) begin
                     bitcnt <= '0;
                     if (shift[7:1] == DEV_ADDR && shift[7:1] != 7'h00) begin
                        oe_q   <= 1'b1;
                        busy_q <= 1'b1;
                        rw     <= shift[0];
                        state  <= ADDR_ACK;
                     end else begin
                        oe_q   <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  bitcnt <= '0;
                  if (rw) begin
                     // reg_rdata reflects reg_addr before this increment.
                     re_q  <= 1'b1;
                     shift <= bus.reg_rdata;
                     ptr   <= ptr + 8'd1;
                     oe_q  <= ~bus.reg_rdata[7];
                     state <= RDATA;
                  end else begin
                     oe_q  <= 1'b0;
                     state <= PTR;
                  end
               end
               PTR: begin
                  if (bitcnt == 4'd8) begin
                     bitcnt <= '0;
                     ptr    <= shift;
                     oe_q   <= 1'b1;
                     state  <= PTR_ACK;
                  end
               end
               PTR_ACK, WDATA_ACK: begin
                  oe_q   <= 1'b0;
                  bitcnt <= '0;
                  state  <= WDATA;
               end
               WDATA: begin
                  if (bitcnt == 4'd8) begin
                     bitcnt <= '0;
                     we_q   <= 1'b1;
                     wdata  <= shift;
                     oe_q   <= 1'b1;
                     state  <= WDATA_ACK;
                  end
               end
               RDATA: begin
                  if (bitcnt == 4'd7) begin
                     oe_q   <= 1'b0;
                     bitcnt <= '0;
                     state  <= RDATA_ACK;
                  end else begin
                     shift  <= {shift[6:0], 1'b0};
                     oe_q   <= ~shift[6];
                     bitcnt <= bitcnt + 4'd1;
                  end
               end
               RDATA_ACK: begin
                  // Only reached after an ACK was sampled on the preceding rise.
                  re_q   <= 1'b1;
                  shift  <= bus.reg_rdata;
                  ptr    <= ptr + 8'd1;
                  oe_q   <= ~bus.reg_rdata[7];
                  bitcnt <= '0;
                  state  <= RDATA;
               end
               default: oe_q <= 1'b0;
            endcase
         end
      end
   end

   assign bus.sda_oe    = oe_q;
   assign bus.reg_addr  = ptr;
   assign bus.reg_wdata = wdata;
   assign bus.reg_we    = we_q;
   assign bus.reg_re    = re_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench for i2c_reg_target: a bit-banged I2C master on an
// open-drain SDA model, a register file behind reg_addr, and a table of
// write transactions plus hand-written multi-cycle sequences.
module tb_i2c_reg_target;
   localparam int H = 10;
   localparam int Q = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   int   cyc = 0;
   int   fall_cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [7:0] regfile [256] = '{default: 8'h00};
   logic [7:0] we_addr_log [1024];
   logic [7:0] we_data_log [1024];
   int   we_cnt = 0, re_cnt = 0, oe_cnt = 0, busy_cnt = 0;
   int   oe_rise_cyc = -100, oe_fall_cyc = -100;
   logic oe_prev = 1'b0;

   i2c_reg_target_if bus ();
   assign bus.scl_in    = scl_m;
   assign bus.sda_in    = sda_m & ~bus.sda_oe;
   assign bus.reg_rdata = regfile[bus.reg_addr];

   i2c_reg_target #(.DEV_ADDR(7'h76)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.reg_we) begin
         we_addr_log[we_cnt % 1024] = bus.reg_addr;
         we_data_log[we_cnt % 1024] = bus.reg_wdata;
         regfile[bus.reg_addr] = bus.reg_wdata;
         we_cnt++;
      end
      if (bus.reg_re) re_cnt++;
      if (bus.sda_oe) oe_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.sda_oe && !oe_prev) oe_rise_cyc = cyc;
      if (!bus.sda_oe && oe_prev) oe_fall_cyc = cyc;
      oe_prev = bus.sda_oe;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_lat(input string name, input int d);
      n_cmp++;
      if (d < 1 || d > 3) begin
         n_bad++;
         $display("FAIL %s: got %0d clk, want 1..3 clk", name, d);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; fall_cyc = cyc;
   endtask

   task automatic m_stop();
      tick(Q); sda_m = 1'b0;
      tick(Q); scl_m = 1'b1;
      tick(Q); sda_m = 1'b1;
      tick(H);
   endtask

   task automatic send_bit(input logic b);
      tick(Q); sda_m = b;
      tick(Q); scl_m = 1'b1;
      tick(H); scl_m = 1'b0; fall_cyc = cyc;
   endtask

   task automatic recv_bit(output logic b);
      tick(Q); sda_m = 1'b1;
      tick(Q); scl_m = 1'b1;
      tick(Q); b = bus.sda_in;
      tick(Q); scl_m = 1'b0; fall_cyc = cyc;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) recv_bit(d[i]);
      send_bit(ack ? 1'b0 : 1'b1);
   endtask

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ptr;
      logic [7:0] data;
      logic [2:0] exp_ack;
      int         exp_we;
      logic [7:0] exp_addr;
      logic [7:0] exp_data;
      logic [7:0] exp_ptr_end;
      logic       exp_busy;
   } wvec_t;

   wvec_t vec [6];

   initial begin
      logic       a0, a1, a2, b;
      logic [7:0] rd;
      logic [7:0] dev_w;
      int         we0, re0, oe0, busy0, f8, f9;

      vec[0] = '{8'hEC, 8'h49, 8'hC0, 3'b111, 1, 8'h49, 8'hC0, 8'h4A, 1'b1};
      vec[1] = '{8'hEC, 8'h00, 8'hA5, 3'b111, 1, 8'h00, 8'hA5, 8'h01, 1'b1};
      vec[2] = '{8'hEC, 8'hFF, 8'h3C, 3'b111, 1, 8'hFF, 8'h3C, 8'h00, 1'b1};
      vec[3] = '{8'hEC, 8'h7F, 8'h80, 3'b111, 1, 8'h7F, 8'h80, 8'h80, 1'b1};
      vec[4] = '{8'hEE, 8'h12, 8'h34, 3'b000, 0, 8'h00, 8'h00, 8'h80, 1'b0};
      vec[5] = '{8'h00, 8'h12, 8'h34, 3'b000, 0, 8'h00, 8'h00, 8'h80, 1'b0};

      // Reset state
      tick(4);
      reset = 1'b0;
      tick(2);
      chk("rst_sda_oe", 32'(bus.sda_oe), 0);
      chk("rst_reg_we", 32'(bus.reg_we), 0);
      chk("rst_reg_re", 32'(bus.reg_re), 0);
      chk("rst_reg_addr", 32'(bus.reg_addr), 0);
      chk("rst_busy", 32'(bus.busy), 0);

      // ACK timing on the address byte, then a write to 0x05
      we0 = we_cnt;
      dev_w = 8'hEC;
      m_start();
      for (int i = 7; i >= 0; i--) send_bit(dev_w[i]);
      f8 = fall_cyc;
      tick(Q); sda_m = 1'b1;
      chk("ack_oe_after_8th_fall", 32'(bus.sda_oe), 1);
      chk_lat("ack_rise_latency", oe_rise_cyc - f8);
      tick(Q); scl_m = 1'b1;
      tick(1);
      chk("ack_hold_early_high", 32'(bus.sda_oe), 1);
      tick(H - 2);
      chk("ack_hold_late_high", 32'(bus.sda_oe), 1);
      tick(1); scl_m = 1'b0; f9 = cyc;
      tick(Q);
      chk("ack_release_after_9th_fall", 32'(bus.sda_oe), 0);
      chk_lat("ack_fall_latency", oe_fall_cyc - f9);
      write_byte(8'h05, a1);
      write_byte(8'h9A, a2);
      m_stop();
      chk("t6_acks", 32'({a1, a2}), 'b11);
      chk("t6_we_cnt", 32'(we_cnt - we0), 1);
      chk("t6_we_addr", 32'(we_addr_log[we0 % 1024]), 'h05);
      chk("t6_we_data", 32'(we_data_log[we0 % 1024]), 'h9A);

      // Table of single-byte write transactions
      for (int i = 0; i < 6; i++) begin
         we0 = we_cnt;
         m_start();
         write_byte(vec[i].dev, a0);
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vec[i].exp_busy));
         write_byte(vec[i].ptr, a1);
         write_byte(vec[i].data, a2);
         chk($sformatf("v%0d_acks", i), 32'({a0, a1, a2}), 32'(vec[i].exp_ack));
         chk($sformatf("v%0d_we_cnt", i), 32'(we_cnt - we0), 32'(vec[i].exp_we));
         if (vec[i].exp_we == 1) begin
            chk($sformatf("v%0d_we_addr", i), 32'(we_addr_log[we0 % 1024]), 32'(vec[i].exp_addr));
            chk($sformatf("v%0d_we_data", i), 32'(we_data_log[we0 % 1024]), 32'(vec[i].exp_data));
         end
         chk($sformatf("v%0d_ptr_end", i), 32'(bus.reg_addr), 32'(vec[i].exp_ptr_end));
         m_stop();
         chk($sformatf("v%0d_busy_stop", i), 32'(bus.busy), 0);
      end

      // Foreign address: never ACKed, no strobes, busy stays low
      we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
      m_start();
      write_byte(8'hA0, a0);
      write_byte(8'h55, a1);
      m_stop();
      chk("t2_oe_cycles", 32'(oe_cnt - oe0), 0);
      chk("t2_we_cnt", 32'(we_cnt - we0), 0);
      chk("t2_re_cnt", 32'(re_cnt - re0), 0);
      chk("t2_busy_cycles", 32'(busy_cnt - busy0), 0);

      // Burst write to load 0x33/0x34
      we0 = we_cnt;
      m_start();
      write_byte(8'hEC, a0);
      write_byte(8'h33, a1);
      write_byte(8'h08, a2);
      write_byte(8'h16, b);
      m_stop();
      chk("burst_acks", 32'({a0, a1, a2, b}), 'b1111);
      chk("burst_we_cnt", 32'(we_cnt - we0), 2);
      chk("burst_ptr_end", 32'(bus.reg_addr), 'h35);

      // Pointer then read via repeated START
      we0 = we_cnt; re0 = re_cnt;
      m_start();
      write_byte(8'hEC, a0);
      write_byte(8'h33, a1);
      m_start();
      write_byte(8'hED, a2);
      chk("rd_acks", 32'({a0, a1, a2}), 'b111);
      read_byte(1'b1, rd);
      chk("rd_byte0", 32'(rd), 'h08);
      read_byte(1'b0, rd);
      chk("rd_byte1", 32'(rd), 'h16);
      m_stop();
      chk("rd_re_cnt", 32'(re_cnt - re0), 2);
      chk("rd_we_cnt", 32'(we_cnt - we0), 0);
      chk("rd_ptr_end", 32'(bus.reg_addr), 'h35);
      chk("rd_busy_stop", 32'(bus.busy), 0);

      // Pointer wrap inside a burst
      we0 = we_cnt;
      m_start();
      write_byte(8'hEC, a0);
      write_byte(8'hFF, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, b);
      m_stop();
      chk("wrap_we_cnt", 32'(we_cnt - we0), 2);
      chk("wrap_we_addr0", 32'(we_addr_log[we0 % 1024]), 'hFF);
      chk("wrap_we_data0", 32'(we_data_log[we0 % 1024]), 'h11);
      chk("wrap_we_addr1", 32'(we_addr_log[(we0 + 1) % 1024]), 'h00);
      chk("wrap_we_data1", 32'(we_data_log[(we0 + 1) % 1024]), 'h22);
      chk("wrap_ptr_end", 32'(bus.reg_addr), 'h01);

      // STOP after 4 data bits discards the partial byte
      we0 = we_cnt;
      m_start();
      write_byte(8'hEC, a0);
      write_byte(8'h10, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      m_stop();
      chk("part_we_cnt", 32'(we_cnt - we0), 0);
      chk("part_busy", 32'(bus.busy), 0);
      chk("part_ptr", 32'(bus.reg_addr), 'h10);

      // Reset in the middle of a read (0x10 holds 0x00, so SDA is pulled)
      m_start();
      write_byte(8'hED, a0);
      chk("rst_rd_ack", 32'(a0), 1);
      recv_bit(b);
      recv_bit(b);
      tick(Q);
      chk("rst_rd_oe_before", 32'(bus.sda_oe), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_rd_oe_after", 32'(bus.sda_oe), 0);
      chk("rst_rd_ptr", 32'(bus.reg_addr), 0);
      #1;
      reset = 1'b0;
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(H);
      chk("rst_rd_busy", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
